// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, PC step, fetch entry type and default reset PC for fetch_queue
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO with flush, occupancy count and push/pop
module fetch_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // next pointers, occupancy and storage contents; flush empties everything
  always_comb begin
    mem_d = mem_q;
    if (push && !flush) mem_d[wp_q] = wdata;
    wp_d = flush ? '0 : wp_q + PW'(push);
    rp_d = flush ? '0 : rp_q + PW'(pop);
    cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  // pointer and occupancy registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  // storage needs no reset: the head is only observed while occupied
  always_ff @(posedge clk) mem_q <= mem_d;
  assign rdata = mem_q[rp_q];
  assign count = cnt_q;
  assign empty = cnt_q == '0;
  assign full = cnt_q == CW'(DEPTH);
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC, prefetch FIFO and redirect handling; FETCH_BYPASS_EN enables empty-queue bypass
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_en,
  output logic [ADDR_W-1:0]          im_addr,
  input  logic [INSTR_W-1:0]         im_rdata,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [ADDR_W-1:0]          out_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       misalign_err
);
  localparam int EW = INSTR_W + ADDR_W;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic misalign_q, misalign_d;
  logic pop, push, byp, fifo_push, fifo_pop, empty, full;
  logic [EW-1:0] head;
  logic [INSTR_W-1:0] head_instr;
  logic [ADDR_W-1:0] head_pc;
`ifdef FETCH_BYPASS_EN
  assign byp = empty && fetch_en && !redirect_valid;
`else
  assign byp = 1'b0;
`endif
  // handshake, push qualification and next fetch PC; redirect wins over everything
  always_comb begin
    pop = out_valid && out_ready;
    push = fetch_en && !redirect_valid && (!full || pop);
    fifo_push = push && !(byp && out_ready);
    fifo_pop = pop && !empty;
    pc_d = redirect_valid ? {redirect_pc[ADDR_W-1:2], 2'b00} : push ? pc_q + ADDR_W'(PC_STEP) : pc_q;
    misalign_d = redirect_valid && (redirect_pc[1:0] != 2'b00);
  end
  // fetch PC and misalign pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      misalign_q <= misalign_d;
    end
  end
  fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush(redirect_valid),
    .push(fifo_push),
    .pop(fifo_pop),
    .wdata({im_rdata, pc_q}),
    .rdata(head),
    .count(count),
    .empty(empty),
    .full(full)
  );
  assign {head_instr, head_pc} = head;
  assign im_addr = pc_q;
  assign misalign_err = misalign_q;
  assign out_valid = !empty || byp;
  assign out_instr = !empty ? head_instr : byp ? im_rdata : '0;
  assign out_pc = !empty ? head_pc : byp ? pc_q : '0;
  assign out_pc_plus4 = out_valid ? out_pc + ADDR_W'(PC_STEP) : '0;
endmodule
